dcache_write_buffer: RTL



---
 rtl/dcache_wb_pkg.sv | 26 ++
 rtl/dcache_wb_fifo.sv | 103 ++++++++++
 rtl/dcache_write_buffer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_pkg.sv
// Shared types for the D-cache eviction write buffer.
// Latency: n/a (types and default geometry only).
// Backpressure: n/a.
package dcache_wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_LINE_W = 256;
    localparam int WB_DEPTH  = 4;
    localparam int WB_OFF_W  = $clog2(WB_LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        DRAIN     = 2'd2,
        RESP      = 2'd3
    } wb_state_t;

    // One buffered line at the default geometry; the FIFO builds the same
    // layout from its own parameters so non-default sizes still work.
    typedef struct packed {
        logic                          vld;
        logic [WB_ADDR_W-WB_OFF_W-1:0] tag;
        logic [WB_LINE_W-1:0]          line;
    } wb_entry_t;

endpackage

// File: rtl/dcache_wb_fifo.sv
// Circular store of evicted lines with a parallel tag match over all entries.
// Latency: push/pop/overwrite take effect on the next clk edge; match is combinational.
// Backpressure: none internally; the owner never pushes when full or pops when empty.
// Ports: lookup_tag -> hit (+ hit_line when DCACHE_WB_READ_FWD_EN is defined);
//        push/push_tag/push_line allocate at tail; pop frees the head;
//        ovr/ovr_line rewrite the matched entry; head_tag/head_line/count/full report state.
module dcache_wb_fifo
    import dcache_wb_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int LINE_W = WB_LINE_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_W-$clog2(LINE_W/8)-1:0]   lookup_tag,
    output logic                                 hit,
`ifdef DCACHE_WB_READ_FWD_EN
    output logic [LINE_W-1:0]                    hit_line,
`endif
    input  logic                                 push,
    input  logic [ADDR_W-$clog2(LINE_W/8)-1:0]   push_tag,
    input  logic [LINE_W-1:0]                    push_line,
    input  logic                                 pop,
    input  logic                                 ovr,
    input  logic [LINE_W-1:0]                    ovr_line,
    output logic [ADDR_W-$clog2(LINE_W/8)-1:0]   head_tag,
    output logic [LINE_W-1:0]                    head_line,
    output logic [$clog2(DEPTH+1)-1:0]           count,
    output logic                                 full
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              vld;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] line;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [DEPTH-1:0]   hit_oh;

    // Writes to an already-buffered tag are merged in place, so at most one
    // entry can match and hit_oh stays one-hot.
    always_comb begin
        hit_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_oh[i] = mem[i].vld && (mem[i].tag == lookup_tag);
        end
    end

    assign hit = |hit_oh;

`ifdef DCACHE_WB_READ_FWD_EN
    always_comb begin
        hit_line = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit_oh[i]) begin
                hit_line = hit_line | mem[i].line;
            end
        end
    end
`endif

    assign head_tag  = mem[head].tag;
    assign head_line = mem[head].line;
    assign full      = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= '{vld: 1'b1, tag: push_tag, line: push_line};
                tail      <= tail + PTR_W'(1);
            end
            if (ovr) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (hit_oh[i]) begin
                        mem[i].line <= ovr_line;
                    end
                end
            end
            if (pop) begin
                mem[head].vld <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/dcache_write_buffer.sv
// Eviction write buffer between the L1 D-cache memory port and the I/D arbiter.
// Latency: write accept / read hit respond 1 cycle after the request is seen in IDLE; a read miss responds 1 cycle after a_pmem_resp.
// Backpressure: requests are held by the D-cache until d_pmem_resp; a non-matching write to a full buffer waits for one drain.
// Ports: d_pmem_* is the D-cache side (read/write held until resp, registered rdata);
//        a_pmem_* is the arbiter side with the same protocol (one request at a time).
// Build option: DCACHE_WB_READ_FWD_EN serves reads that hit the buffer directly;
//        without it such reads drain the buffer until no copy remains, then miss to L2.
module dcache_write_buffer
    import dcache_wb_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int LINE_W = WB_LINE_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              a_pmem_read,
    output logic              a_pmem_write,
    output logic [ADDR_W-1:0] a_pmem_address,
    output logic [LINE_W-1:0] a_pmem_wdata,
    input  logic [LINE_W-1:0] a_pmem_rdata,
    input  logic              a_pmem_resp
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_state_t          state;
    wb_state_t          state_nxt;
    logic [LINE_W-1:0]  rdata_q;

    logic               hit;
    logic               full;
    logic               push;
    logic               pop;
    logic               ovr;
    logic [TAG_W-1:0]   req_tag;
    logic [TAG_W-1:0]   head_tag;
    logic [LINE_W-1:0]  head_line;
    logic [CNT_W-1:0]   count;
`ifdef DCACHE_WB_READ_FWD_EN
    logic [LINE_W-1:0]  hit_line;
`endif

    assign req_tag = d_pmem_address[ADDR_W-1:OFF_W];

    dcache_wb_fifo #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_tag (req_tag),
        .hit        (hit),
`ifdef DCACHE_WB_READ_FWD_EN
        .hit_line   (hit_line),
`endif
        .push       (push),
        .push_tag   (req_tag),
        .push_line  (d_pmem_wdata),
        .pop        (pop),
        .ovr        (ovr),
        .ovr_line   (d_pmem_wdata),
        .head_tag   (head_tag),
        .head_line  (head_line),
        .count      (count),
        .full       (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Buffer updates are issued only from IDLE (accept) and DRAIN (pop), so
    // push, pop and overwrite never coincide.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pop       = 1'b0;
        ovr       = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_pmem_read) begin
`ifdef DCACHE_WB_READ_FWD_EN
                    state_nxt = hit ? RESP : READ_MISS;
`else
                    // L2 must not return a line older than a buffered copy.
                    state_nxt = hit ? DRAIN : READ_MISS;
`endif
                end else if (d_pmem_write) begin
                    if (hit) begin
                        ovr       = 1'b1;
                        state_nxt = RESP;
                    end else if (!full) begin
                        push      = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        // Make room; the held write is retried back in IDLE.
                        state_nxt = DRAIN;
                    end
                end else if (count != '0) begin
                    state_nxt = DRAIN;
                end
            end
            READ_MISS: begin
                if (a_pmem_resp) begin
                    state_nxt = RESP;
                end
            end
            DRAIN: begin
                if (a_pmem_resp) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (state == READ_MISS && a_pmem_resp) begin
            rdata_q <= a_pmem_rdata;
`ifdef DCACHE_WB_READ_FWD_EN
        end else if (state == IDLE && d_pmem_read && hit) begin
            rdata_q <= hit_line;
`endif
        end
    end

    // Downstream outputs decode straight from the state register so a reset
    // drops them immediately, and read/write are exclusive by construction.
    always_comb begin
        a_pmem_read    = 1'b0;
        a_pmem_write   = 1'b0;
        a_pmem_address = '0;
        a_pmem_wdata   = '0;
        if (state == READ_MISS) begin
            a_pmem_read    = 1'b1;
            a_pmem_address = d_pmem_address;
        end else if (state == DRAIN) begin
            a_pmem_write   = 1'b1;
            a_pmem_address = {head_tag, {OFF_W{1'b0}}};
            a_pmem_wdata   = head_line;
        end
    end

    assign d_pmem_resp  = (state == RESP);
    assign d_pmem_rdata = rdata_q;

endmodule
